// File: rtl/ti_stop_sequencer.sv
// ti_stop_sequencer: initiator of the task-switch stop handshake; stops channels in order,
// swaps task_id while all are held, releases them, and aborts on an unresponsive channel.
module ti_stop_sequencer #(
  parameter int NUM_CH         = 2,
  parameter int TASK_W         = 1,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int HOLD_CYCLES    = 4
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     cmd_valid,
  output logic                                     cmd_ready,
  input  logic [TASK_W-1:0]                        cmd_task_id,
  output logic [NUM_CH-1:0]                        stop_req,
  input  logic [NUM_CH-1:0]                        stop_ack,
  output logic [TASK_W-1:0]                        task_id,
  output logic                                     busy,
  output logic                                     all_stopped,
  output logic                                     swap_done,
  output logic                                     swap_err,
  output logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] err_ch
);
  localparam int CW = $clog2(NUM_CH > 1 ? NUM_CH : 2);
  localparam int TW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE, REQ, HOLD, RELEASE, ABORT, FINISH} state_t;
  state_t state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d, err_ch_q, err_ch_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [NUM_CH-1:0] stop_req_q, stop_req_d;
  logic [TASK_W-1:0] task_id_q, task_id_d, tgt_q, tgt_d;
  logic              timeout;
  assign timeout     = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign cmd_ready   = state_q == IDLE;
  assign busy        = state_q != IDLE;
  assign stop_req    = stop_req_q;
  assign task_id     = task_id_q;
  assign err_ch      = err_ch_q;
  assign all_stopped = (&stop_ack) && (&stop_req_q);
  // pulses are masked while reset is held so a reset never reports an outcome
  assign swap_done   = (state_q == FINISH) && !rst;
  assign swap_err    = (state_q == ABORT) && (stop_ack == '0) && !rst;
  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    err_ch_d   = err_ch_q;
    timer_d    = timer_q;
    hold_d     = hold_q;
    stop_req_d = stop_req_q;
    task_id_d  = task_id_q;
    tgt_d      = tgt_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        err_ch_d = '0;
        tgt_d    = cmd_task_id;
        ch_d     = '0;
        timer_d  = '0;
        hold_d   = '0;
        state_d  = (cmd_task_id == task_id_q) ? FINISH : REQ;
        stop_req_d = (cmd_task_id == task_id_q) ? '0 : NUM_CH'(1);
      end
      REQ: if (stop_ack[ch_q]) begin
        timer_d = '0;
        if (ch_q == CW'(NUM_CH - 1)) state_d = HOLD;
        else begin
          ch_d       = ch_q + 1'b1;
          stop_req_d = stop_req_q | (NUM_CH'(2) << ch_q);
        end
      end else if (timeout) begin
        state_d    = ABORT;
        err_ch_d   = ch_q;
        stop_req_d = '0;
      end else timer_d = timer_q + 1'b1;
      HOLD: begin
        task_id_d = (hold_q == '0) ? tgt_q : task_id_q;
        hold_d    = hold_q + 1'b1;
        if (hold_q == HW'(HOLD_CYCLES - 1)) begin
          state_d    = RELEASE;
          stop_req_d = '0;
        end
      end
      RELEASE: state_d = (stop_ack == '0) ? FINISH : RELEASE;
      ABORT:   state_d = (stop_ack == '0) ? IDLE : ABORT;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      err_ch_q   <= '0;
      timer_q    <= '0;
      hold_q     <= '0;
      stop_req_q <= '0;
      task_id_q  <= '0;
      tgt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      err_ch_q   <= err_ch_d;
      timer_q    <= timer_d;
      hold_q     <= hold_d;
      stop_req_q <= stop_req_d;
      task_id_q  <= task_id_d;
      tgt_q      <= tgt_d;
    end
  end
endmodule

// File: tb/tb_ti_stop_sequencer.sv
// tb_ti_stop_sequencer: directed cycle-by-cycle checks of the stop sequencer with a
// lagging ack follower or hand-driven acks.
module tb_ti_stop_sequencer;
  logic       clk = 0, rst = 1, cmd_valid = 0, cmd_ready, cmd_task_id = 0;
  logic [1:0] stop_req, stop_ack = 0;
  logic       task_id, busy, all_stopped, swap_done, swap_err, err_ch;
  logic [1:0] h0 = 0, h1 = 0, h2 = 0, h3 = 0, dead = 0;
  logic       follow = 0;
  int         n_chk = 0, n_bad = 0;
  ti_stop_sequencer #(.NUM_CH(2), .TASK_W(1), .TIMEOUT_CYCLES(16), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_task_id(cmd_task_id), .stop_req(stop_req), .stop_ack(stop_ack),
    .task_id(task_id), .busy(busy), .all_stopped(all_stopped),
    .swap_done(swap_done), .swap_err(swap_err), .err_ch(err_ch)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // ack follower: each ack bit repeats its stop_req bit three cycles late
  task automatic tick();
    @(posedge clk);
    #1;
    h3 = h2; h2 = h1; h1 = h0; h0 = stop_req;
    if (follow) stop_ack = h3 & ~dead;
  endtask
  task automatic start(input logic t);
    cmd_valid = 1; cmd_task_id = t;
    tick();
    cmd_valid = 0;
  endtask
  task automatic quiet();
    follow = 0; stop_ack = 0; dead = 0; h0 = 0; h1 = 0; h2 = 0; h3 = 0;
    tick(); tick();
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    #1;
    check("rst_req", stop_req, 0);
    check("rst_task", task_id, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", swap_done, 0);
    check("rst_err", swap_err, 0);
    check("rst_errch", err_ch, 0);
    // full switch 0->1 with acks following requests three cycles late
    follow = 1;
    start(1);
    for (int c = 1; c <= 18; c++) begin
      #1;
      check("t1_req", stop_req, (c <= 4) ? 1 : (c <= 12) ? 3 : 0);
      check("t1_busy", busy, c <= 17);
      check("t1_done", swap_done, c == 17);
      if (c == 9)  check("t1_task_old", task_id, 0);
      if (c == 10) check("t1_task_new", task_id, 1);
      if (c == 18) check("t1_ready", cmd_ready, 1);
      tick();
    end
    quiet();
    // same-task command completes immediately
    start(1);
    #1;
    check("t2_done", swap_done, 1);
    check("t2_req", stop_req, 0);
    tick();
    check("t2_done_end", swap_done, 0);
    check("t2_task", task_id, 1);
    check("t2_ready", cmd_ready, 1);
    quiet();
    // RX never acks: abort after 16 wait cycles
    follow = 1; dead = 2'b10;
    start(0);
    for (int c = 1; c <= 25; c++) begin
      #1;
      check("t3_done", swap_done, 0);
      check("t3_err", swap_err, c == 24);
      if (c == 20) check("t3_req_wait", stop_req, 3);
      if (c == 21) begin
        check("t3_req_drop", stop_req, 0);
        check("t3_errch", err_ch, 1);
        check("t3_busy", busy, 1);
      end
      if (c == 25) begin
        check("t3_ready", cmd_ready, 1);
        check("t3_task", task_id, 1);
      end
      tick();
    end
    quiet();
    // RX ack arrives on the last allowed wait cycle
    start(0);
    for (int c = 1; c <= 28; c++) begin
      stop_ack = {c >= 20 && c <= 25, c >= 4 && c <= 25};
      #1;
      check("t4_err", swap_err, 0);
      check("t4_done", swap_done, c == 27);
      if (c == 21) check("t4_req_hold", stop_req, 3);
      if (c == 22) check("t4_task", task_id, 0);
      if (c == 28) check("t4_ready", cmd_ready, 1);
      tick();
    end
    quiet();
    // reset while holding
    stop_ack = 2'b11;
    start(1);
    for (int c = 1; c <= 6; c++) begin
      if (c == 4) rst = 1;
      if (c == 5) rst = 0;
      #1;
      check("t5_done", swap_done, 0);
      check("t5_err", swap_err, 0);
      if (c == 4) check("t5_task_pre", task_id, 1);
      if (c == 5) begin
        check("t5_req", stop_req, 0);
        check("t5_task", task_id, 0);
        check("t5_busy", busy, 0);
      end
      tick();
    end
    quiet();
    // acks pre-held: minimum latency
    stop_ack = 2'b11;
    start(1);
    for (int c = 1; c <= 10; c++) begin
      stop_ack = (c >= 8) ? 2'b00 : 2'b11;
      #1;
      check("t6_done", swap_done, c == 9);
      if (c == 1) begin
        check("t6_req1", stop_req, 1);
        check("t6_allstop1", all_stopped, 0);
      end
      if (c == 2) check("t6_req2", stop_req, 3);
      if (c == 3) check("t6_allstop3", all_stopped, 1);
      if (c == 7) check("t6_req7", stop_req, 0);
      if (c == 10) begin
        check("t6_ready", cmd_ready, 1);
        check("t6_task", task_id, 1);
      end
      tick();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
